// File: rtl/axi_rd_burst_sched.sv
// AXI4 read burst scheduler: splits one (addr, bytes) command into 4 KB-safe INCR bursts.
// Optional read watchdog enabled by defining AXI_RD_BURST_SCHED_TIMEOUT_EN.
module axi_rd_burst_sched #(
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int AXI_ID          = 0,
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_addr,
  input  logic [15:0]       cmd_bytes,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [31:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              sts_valid,
  output logic [1:0]        sts_resp,
  output logic [15:0]       sts_beats,
  output logic              busy
`ifdef AXI_RD_BURST_SCHED_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  localparam int BPB = DATA_W / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] ADDR_MASK = 32'(BPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     remain_q, remain_d;
  logic [15:0]     total_q, total_d;
  logic [15:0]     rcv_q, rcv_d;
  logic [1:0]      resp_q, resp_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            arvalid_q, arvalid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic            out_en_q, out_en_d;

  logic            active;
  logic            cmd_hs;
  logic            ar_hs;
  logic            r_hs;
  logic [16:0]     bytes_rounded;
  logic [15:0]     cmd_beats;
  logic [12:0]     to_4k_bytes;
  logic [12:0]     to_4k_beats;
  logic [16:0]     burst_size;
  logic [15:0]     burst_beats;
  logic [31:0]     burst_bytes;
  logic            unused_ok;

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign cmd_ready = (state_q == S_IDLE) && out_en_q;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;

  assign bytes_rounded = {1'b0, cmd_bytes} + 17'(BPB - 1);
  assign cmd_beats     = 16'(bytes_rounded >> SZ);

  // Largest burst that neither runs past the command nor crosses the next 4 KB page
  assign to_4k_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
  assign to_4k_beats = to_4k_bytes >> SZ;

  always_comb begin
    burst_size = {1'b0, remain_q};
    if (burst_size > 17'(MAX_BURST)) begin
      burst_size = 17'(MAX_BURST);
    end
    if (burst_size > {4'd0, to_4k_beats}) begin
      burst_size = {4'd0, to_4k_beats};
    end
  end

  // Size of the burst currently on AR, taken from its registered length
  assign burst_beats = {8'd0, arlen_q} + 16'd1;
  assign burst_bytes = ({24'd0, arlen_q} + 32'd1) << SZ;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      total_q   <= '0;
      rcv_q     <= '0;
      resp_q    <= '0;
      outst_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      total_q   <= total_d;
      rcv_q     <= rcv_d;
      resp_q    <= resp_d;
      outst_q   <= outst_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      out_en_q  <= out_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          state_d = (cmd_beats == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (ar_hs && (remain_q == burst_beats)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((outst_q == '0) && (rcv_q == total_q)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    remain_d  = remain_q;
    total_d   = total_q;
    rcv_d     = rcv_q;
    resp_d    = resp_q;
    outst_d   = outst_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    out_en_d  = 1'b1;

    if (cmd_hs) begin
      addr_d   = cmd_addr & ~ADDR_MASK;
      remain_d = cmd_beats;
      total_d  = cmd_beats;
      rcv_d    = '0;
      resp_d   = 2'b00;
    end

    // AR is registered; a new request is only prepared in a cycle with no AR pending
    if (state_q == S_RUN) begin
      if (ar_hs) begin
        arvalid_d = 1'b0;
        addr_d    = addr_q + burst_bytes;
        remain_d  = remain_q - burst_beats;
      end else if (!arvalid_q && (remain_q != 16'd0) &&
                   (outst_q < OW'(MAX_OUTSTANDING))) begin
        arvalid_d = 1'b1;
        araddr_d  = addr_q;
        arlen_d   = 8'(burst_size - 17'd1);
      end
    end

    if (r_hs) begin
      rcv_d = rcv_q + 16'd1;
      if (m_axi_rresp == 2'b11) begin
        resp_d = 2'b11;
      end else if ((m_axi_rresp == 2'b10) && (resp_q != 2'b11)) begin
        resp_d = 2'b10;
      end
    end

    case ({ar_hs, r_hs && m_axi_rlast})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    m_axi_arid    = out_en_q ? ID_W'(AXI_ID) : '0;
    m_axi_arsize  = out_en_q ? 3'(SZ) : 3'd0;
    m_axi_arburst = out_en_q ? 2'b01 : 2'b00;
    m_axi_araddr  = araddr_q;
    m_axi_arlen   = arlen_q;
    m_axi_arvalid = arvalid_q;
    m_axi_rready  = active && m_axis_tready;
    m_axis_tvalid = active && m_axi_rvalid;
    m_axis_tdata  = active ? m_axi_rdata : '0;
    m_axis_tlast  = active && m_axi_rvalid && m_axi_rlast && (rcv_q == total_q - 16'd1);
    sts_valid     = (state_q == S_DONE);
    sts_beats     = rcv_q;
    busy          = (state_q != S_IDLE);
  end

`ifdef AXI_RD_BURST_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Watchdog measures silence on R while bursts are owed to us
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (cmd_hs || r_hs) begin
      wd_d = '0;
    end else if (active && (outst_q != '0) && (wd_q != TW'(TIMEOUT_CYCLES))) begin
      wd_d = wd_q + TW'(1);
    end
    if (cmd_hs) begin
      err_d = 1'b0;
    end else if (wd_d == TW'(TIMEOUT_CYCLES)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
  assign sts_resp    = (err_q && (resp_q == 2'b00)) ? 2'b10 : resp_q;
  assign unused_ok   = ^m_axi_rid;
`else
  assign sts_resp  = resp_q;
  assign unused_ok = ^{m_axi_rid, 1'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Directed + randomized bench for axi_rd_burst_sched with an AXI read slave and burst-split model.
module tb_axi_rd_burst_sched;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int MAX_B   = 256;
  localparam int MAX_OUT = 4;
  localparam int BPB     = DATA_W / 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [31:0]       cmd_addr = '0;
  logic [15:0]       cmd_bytes = '0;
  logic [ID_W-1:0]   m_axi_arid;
  logic [31:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready = 1'b0;
  logic [ID_W-1:0]   m_axi_rid = '0;
  logic [DATA_W-1:0] m_axi_rdata = '0;
  logic [1:0]        m_axi_rresp = '0;
  logic              m_axi_rlast = 1'b0;
  logic              m_axi_rvalid = 1'b0;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              sts_valid;
  logic [1:0]        sts_resp;
  logic [15:0]       sts_beats;
  logic              busy;
`ifdef AXI_RD_BURST_SCHED_TIMEOUT_EN
  logic              err_timeout;
`endif

  always #5 aclk = ~aclk;

  axi_rd_burst_sched #(
    .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .MAX_BURST(MAX_B),
    .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(1024)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .sts_valid(sts_valid), .sts_resp(sts_resp), .sts_beats(sts_beats), .busy(busy)
`ifdef AXI_RD_BURST_SCHED_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          last_resp;
  int          last_beats;
  logic [31:0] obs_addr[$];
  int          obs_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rank(input logic [1:0] r);
    return (r == 2'b11) ? 2 : ((r == 2'b10) ? 1 : 0);
  endfunction

  task automatic chk_outputs_zero(input string tag);
    logic any;
    any = |{cmd_ready, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
            sts_valid, sts_resp, sts_beats, busy};
    chk(tag, 64'(any), 64'd0);
  endtask

  task automatic clear_inputs();
    cmd_valid = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0; m_axis_tready = 1'b0;
  endtask

  // One command end to end: reference split into bursts, slave model, stream and status checks
  task automatic run_cmd(input logic [31:0] addr, input int bytes, input int hold,
                         input int err_a, input int err_b, input bit rnd_err, input int abort_at);
    logic [31:0] ba[$];
    int          bl[$];
    int          sl_len[$];
    logic [31:0] a;
    int rem, n, to4k, total, nb, acc_cyc, beats_rx, worst, ar_cnt, bursts_done, sl_beat, exp_resp;
    bit accepted, done, aborted, rv, prev_pend;
    logic [31:0] prev_addr, cur_data;
    logic [7:0]  prev_len;
    logic [1:0]  cur_resp;
    logic        cur_last;

    total = (bytes + BPB - 1) / BPB;
    a = addr & ~32'(BPB - 1);
    rem = total;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / BPB;
      n = rem;
      if (n > MAX_B) n = MAX_B;
      if (n > to4k) n = to4k;
      ba.push_back(a);
      bl.push_back(n - 1);
      a += 32'(n * BPB);
      rem -= n;
    end
    nb = ba.size();
    obs_addr.delete();
    obs_len.delete();
    acc_cyc = 0; beats_rx = 0; worst = 0; ar_cnt = 0; bursts_done = 0; sl_beat = 0;
    accepted = 0; done = 0; aborted = 0; rv = 0; prev_pend = 0;
    prev_addr = '0; prev_len = '0; cur_data = '0; cur_resp = '0; cur_last = 0;

    for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
      @(negedge aclk);
      cmd_valid = !accepted;
      cmd_addr  = addr;
      cmd_bytes = 16'(bytes);
      m_axi_arready = ($urandom % 4) != 0;
      m_axis_tready = ($urandom % 4) != 0;
      if (!rv && sl_len.size() > 0 && cyc >= hold && ($urandom % 4) != 0) begin
        rv = 1;
        cur_data = $urandom;
        if (beats_rx == err_a) cur_resp = 2'b10;
        else if (beats_rx == err_b) cur_resp = 2'b11;
        else if (rnd_err && ($urandom % 8) == 0) cur_resp = 2'($urandom);
        else cur_resp = 2'b00;
        cur_last = (sl_beat == sl_len[0] - 1);
      end
      m_axi_rvalid = rv;
      m_axi_rdata  = rv ? cur_data : '0;
      m_axi_rresp  = rv ? cur_resp : 2'b00;
      m_axi_rlast  = rv && cur_last;
      if (cyc == abort_at) begin
        aresetn = 1'b0;
        #1;
        chk_outputs_zero("abort_outputs_zero");
        aborted = 1;
        break;
      end
      #1;
      if (cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_cyc = cyc;
      end
      if (prev_pend) begin
        chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
        chk("ar_hold_addr", 64'(m_axi_araddr), 64'(prev_addr));
        chk("ar_hold_len", 64'(m_axi_arlen), 64'(prev_len));
      end
      prev_pend = m_axi_arvalid && !m_axi_arready;
      prev_addr = m_axi_araddr;
      prev_len  = m_axi_arlen;
      if (m_axi_arvalid && m_axi_arready) begin
        chk("ar_outstanding", 64'((ar_cnt - bursts_done) < MAX_OUT), 64'd1);
        if (ba.size() == 0) begin
          chk("ar_extra", 64'd1, 64'd0);
        end else begin
          chk("araddr", 64'(m_axi_araddr), 64'(ba.pop_front()));
          chk("arlen", 64'(m_axi_arlen), 64'(bl.pop_front()));
        end
        chk("arsize", 64'(m_axi_arsize), 64'd2);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("arid", 64'(m_axi_arid), 64'd0);
        obs_addr.push_back(m_axi_araddr);
        obs_len.push_back(int'(m_axi_arlen));
        sl_len.push_back(int'(m_axi_arlen) + 1);
        ar_cnt++;
      end
      if (rv) begin
        chk("tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("rready", 64'(m_axi_rready), 64'(m_axis_tready));
        if (m_axi_rready) begin
          chk("tdata", 64'(m_axis_tdata), 64'(cur_data));
          chk("tlast", 64'(m_axis_tlast), 64'(beats_rx == total - 1));
          if (rank(cur_resp) > worst) worst = rank(cur_resp);
          beats_rx++;
          sl_beat++;
          rv = 0;
          if (cur_last) begin
            void'(sl_len.pop_front());
            sl_beat = 0;
            bursts_done++;
          end
        end
      end
      if (hold > 0 && cyc == hold) begin
        chk("hold_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("hold_ar_count", 64'(ar_cnt), 64'((nb < MAX_OUT) ? nb : MAX_OUT));
      end
      if (sts_valid) begin
        exp_resp = (worst == 2) ? 3 : ((worst == 1) ? 2 : 0);
        chk("sts_beats", 64'(sts_beats), 64'(total));
        chk("sts_resp", 64'(sts_resp), 64'(exp_resp));
        chk("rx_beats", 64'(beats_rx), 64'(total));
        chk("ar_count", 64'(ar_cnt), 64'(nb));
        if (total == 0) chk("zero_sts_latency", 64'((cyc - acc_cyc) <= 2), 64'd1);
        last_resp  = int'(sts_resp);
        last_beats = int'(sts_beats);
        done = 1;
      end
    end

    if (!done && !aborted) chk("cmd_timeout", 64'd0, 64'd1);
    if (done) begin
      @(negedge aclk);
      clear_inputs();
      #1;
      chk("sts_pulse_once", 64'(sts_valid), 64'd0);
      chk("sts_beats_hold", 64'(sts_beats), 64'(total));
      chk("idle_ready", 64'(cmd_ready), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
      $display("cmd addr=0x%08h bytes=%0d bursts=%0d beats=%0d resp=%0d", addr, bytes, nb, last_beats, last_resp);
    end else if (aborted) begin
      $display("cmd addr=0x%08h bytes=%0d aborted by reset", addr, bytes);
    end
  endtask

  initial begin
    last_resp = 0;
    last_beats = 0;
    #1 aresetn = 1'b0;
    #1;
    chk_outputs_zero("reset_outputs_zero");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    #1;
    chk("ready_after_release", 64'(cmd_ready), 64'd1);
    chk("busy_after_release", 64'(busy), 64'd0);

    run_cmd(32'h1000, 64, 0, -1, -1, 0, -1);
    chk("t1_nbursts", 64'(obs_addr.size()), 64'd1);
    chk("t1_addr", 64'(obs_addr[0]), 64'h1000);
    chk("t1_len", 64'(obs_len[0]), 64'd15);
    chk("t1_beats", 64'(last_beats), 64'd16);
    chk("t1_resp", 64'(last_resp), 64'd0);

    run_cmd(32'h0FF0, 64, 0, -1, -1, 0, -1);
    chk("t2_nbursts", 64'(obs_addr.size()), 64'd2);
    chk("t2_addr0", 64'(obs_addr[0]), 64'h0FF0);
    chk("t2_len0", 64'(obs_len[0]), 64'd3);
    chk("t2_addr1", 64'(obs_addr[1]), 64'h1000);
    chk("t2_len1", 64'(obs_len[1]), 64'd11);

    run_cmd(32'h0, 2048, 0, -1, -1, 0, -1);
    chk("t3_addr1", 64'(obs_addr[1]), 64'h400);
    chk("t3_len1", 64'(obs_len[1]), 64'd255);
    chk("t3_beats", 64'(last_beats), 64'd512);
    run_cmd(32'h40, 6, 0, -1, -1, 0, -1);
    chk("t3_len_6bytes", 64'(obs_len[0]), 64'd1);

    run_cmd(32'h0, 8192, 300, -1, -1, 0, -1);
    chk("t4_beats", 64'(last_beats), 64'd2048);

    run_cmd(32'h200, 64, 0, 2, 8, 0, -1);
    chk("t5_resp", 64'(last_resp), 64'd3);
    run_cmd(32'h123, 0, 0, -1, -1, 0, -1);
    chk("t5_zero_nbursts", 64'(obs_addr.size()), 64'd0);
    chk("t5_zero_beats", 64'(last_beats), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_cmd(32'($urandom_range(0, 16383)), int'($urandom_range(0, 1200)), 0, -1, -1, 1, -1);
    end

    run_cmd(32'h0, 1024, 0, -1, -1, 0, 40);
    clear_inputs();
    repeat (2) @(negedge aclk);
    #1;
    chk_outputs_zero("reset_hold_zero");
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("t6_ready_after_release", 64'(cmd_ready), 64'd1);
    run_cmd(32'h0FFC, 40, 0, -1, -1, 0, -1);
    chk("t6_beats", 64'(last_beats), 64'd10);
    chk("t6_nbursts", 64'(obs_addr.size()), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
